fetch_buffer: RTL and testbench

- Stage directly downstream of the fetch PC generator.
- Takes the per-cycle PC/valid from fetch and issues instruction-memory reads (fixed 1-cycle read latency).
- Queues returned {pc, inst} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Drives back-pressure into fetch's stall input; discards everything on a branch flush.

---
 rtl/core_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 39 +++
 rtl/fetch_buffer.sv | 55 +++++
 tb/tb_fetch_buffer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared fetch-path widths and the {pc, inst} entry carried from fetch to decode.
package core_pkg;
   localparam int XLEN = 32;
   typedef logic [XLEN-1:0] inst_t;
   typedef struct packed {
      inst_t pc;
      inst_t inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular queue of fetched entries with a single-cycle flush.
module fetch_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter type T = fetch_entry_t,
   localparam int AW = $clog2(DEPTH)
)(
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  logic    flush,
   input  T        wdata,
   output T        rdata,
   output logic [AW:0] count,
   output logic    empty,
   output logic    full
);
   T mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_pop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign do_pop = pop & ~empty;
   assign rdata = mem[rd_ptr];
   always_ff @(posedge clk)
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: issues imem reads for fetch PCs, queues returned {pc, inst} pairs for decode,
// and back-pressures fetch so every outstanding read always has a reserved FIFO slot.
module fetch_buffer
   import core_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic  clk,
   input  logic  rst,
   input  logic  fetch_valid,
   input  inst_t fetch_pc,
   input  logic  flush,
   output logic  stall_output,
   output logic  imem_req,
   output inst_t imem_addr,
   input  inst_t imem_rdata,
   input  logic  decode_ready,
   output logic  decode_valid,
   output inst_t decode_pc,
   output inst_t decode_inst
);
   localparam int AW = $clog2(DEPTH);
   logic inflight, push, empty, full;
   inst_t inflight_pc;
   logic [AW:0] fifo_count;
   fetch_entry_t head;
   // Credits count the in-flight read; pops only free a slot once count updates.
   assign stall_output = full | (({1'b0, fifo_count} + (AW+2)'(inflight)) >= (AW+2)'(DEPTH));
   assign imem_req = fetch_valid & ~stall_output & ~flush;
   assign imem_addr = fetch_pc;
   assign push = inflight & ~flush;
   assign decode_valid = ~empty;
   assign decode_pc = head.pc;
   assign decode_inst = head.inst;
   always_ff @(posedge clk)
      if (rst) begin
         inflight <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) inflight_pc <= fetch_pc;
      end
   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(decode_ready),
      .flush(flush),
      .wdata('{pc: inflight_pc, inst: imem_rdata}),
      .rdata(head),
      .count(fifo_count),
      .empty(empty),
      .full(full)
   );
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: random and directed stimulus against a queue-based model with a decoupled pop monitor.
module tb_fetch_buffer;
   localparam int DEPTH = 4;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic clk = 0, rst = 1, fetch_valid = 0, flush = 0, decode_ready = 0;
   logic [31:0] fetch_pc = 0, imem_rdata = 0, imem_addr, decode_pc, decode_inst;
   logic stall_output, imem_req, decode_valid;

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .flush(flush),
      .stall_output(stall_output), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .decode_ready(decode_ready), .decode_valid(decode_valid),
      .decode_pc(decode_pc), .decode_inst(decode_inst)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ 32'hA5A5A5A5) : $urandom;

   int vectors = 0, miscompares = 0, req_cnt = 0;
   exp_t exp_q[$];
   logic [31:0] seen[$];
   logic m_inflight = 0, m_req = 0, e_stall, flush_q = 0;
   logic [31:0] m_pc = 0, next_pc = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: occupancy is simply the expected-entry queue plus one outstanding read.
   always @(negedge clk) begin
      #2;
      if (rst) m_req = 0;
      else begin
         e_stall = (exp_q.size() + int'(m_inflight)) >= DEPTH;
         m_req = fetch_valid && !e_stall && !flush;
         chk("stall_output", 32'(stall_output), 32'(e_stall));
         chk("imem_req", 32'(imem_req), 32'(m_req));
         chk("imem_addr", imem_addr, fetch_pc);
         chk("decode_valid", 32'(decode_valid), 32'(exp_q.size() != 0));
         if (flush_q) chk("inflight_after_flush", 32'(dut.inflight), 0);
         if (m_req) req_cnt++;
      end
      #2;
      if (rst) begin
         exp_q.delete();
         m_inflight = 0;
         flush_q = 0;
      end else begin
         if (m_inflight && !flush) exp_q.push_back('{m_pc, m_pc ^ 32'hA5A5A5A5});
         if (flush) exp_q.delete();
         m_inflight = m_req;
         if (m_req) m_pc = fetch_pc;
         flush_q = flush;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      #3;
      if (!rst && decode_valid && decode_ready) begin
         if (exp_q.size() == 0) chk("unexpected_pop", decode_pc, 32'hFFFFFFFF);
         else begin
            e = exp_q.pop_front();
            chk("decode_pc", decode_pc, e.pc);
            chk("decode_inst", decode_inst, e.inst);
            seen.push_back(decode_pc);
         end
      end
   end

   always @(posedge clk)
      if (!rst) begin
         if (dut.push && dut.fifo_count == 3'(DEPTH)) chk("push_when_full", 1, 0);
         if (dut.u_fifo.do_pop && dut.fifo_count == 3'd0) chk("pop_when_empty", 1, 0);
      end

   task automatic step(input logic v, input logic fl, input logic dr, input logic r);
      @(negedge clk);
      if (m_req) next_pc += 4;
      rst = r;
      fetch_valid = v;
      flush = fl;
      decode_ready = dr;
      fetch_pc = next_pc;
   endtask

   task automatic restart(input logic [31:0] pc);
      step(0, 0, 0, 1);
      next_pc = pc;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step(1, 0, 1, 1);
      next_pc = 0;
      seen.delete();
      for (int i = 0; i < 12; i++) step(1, 0, 1, 0);
      #4;
      chk("stream_first_pc", seen.size() > 0 ? seen[0] : 32'hDEADBEEF, 32'h0);
      chk("stream_count", 32'(seen.size()), 32'd10);

      restart(0);
      req_cnt = 0;
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
      #3;
      chk("backpressure_reqs", 32'(req_cnt), 32'd4);
      seen.delete();
      for (int i = 0; i < 10; i++) step(1, 0, 1, 0);
      #4;
      chk("bp_drain_pc3", seen.size() > 4 ? seen[3] : 32'hDEADBEEF, 32'hC);
      chk("bp_resume_pc", seen.size() > 4 ? seen[4] : 32'hDEADBEEF, 32'h10);

      restart(0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      next_pc = 32'h100;
      seen.delete();
      for (int i = 0; i < 6; i++) step(1, 0, 1, 0);
      #4;
      chk("flush_target", seen.size() > 0 ? seen[0] : 32'hDEADBEEF, 32'h100);

      restart(0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 0, 1, 0);

      restart(0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
      step(1, 0, 1, 1);
      next_pc = 32'h200;
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      seen.delete();
      for (int i = 0; i < 6; i++) step(1, 0, 1, 0);
      #4;
      chk("post_reset_pc", seen.size() > 0 ? seen[0] : 32'hDEADBEEF, 32'h200);

      restart(32'h1000);
      for (int i = 0; i < 120; i++) begin
         logic fl;
         fl = $urandom_range(0, 15) == 0;
         step($urandom_range(0, 3) != 0, fl, 1'($urandom), 0);
         if (fl) next_pc = $urandom & 32'hFFFFFFFC;
      end
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
      #4;
      chk("final_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
